// File: rtl/prio_seg_display.sv
`default_nettype none
// prio_seg_display rev 1.0: synchronised priority encoder -> double-dabble BCD -> multiplexed 7-seg.
// Macro PRIO_SEG_LZ_BLANK_EN enables leading-zero blanking of the upper digits.
module prio_seg_display #(
  parameter int N           = 16,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in,
  output logic [6:0]           seg_out,
  output logic [DIGITS-1:0]    an,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx,
  output logic                 busy
);
  localparam int OUTW = $clog2(N);
  localparam int BW   = 4 * DIGITS;
  localparam int CW   = $clog2(OUTW + 1);
  localparam int SCW  = $clog2(REFRESH_DIV);
  localparam int DSW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  logic [N-1:0]    sync1, sync2;
  logic [OUTW-1:0] enc;
  state_t          state;
  logic            pending;
  logic [OUTW-1:0] conv_idx, bin_work;
  logic            conv_valid, bcd_valid;
  logic [BW-1:0]   bcd_work, bcd_adj, bcd;
  logic [CW-1:0]   shift_cnt;
  logic            changed;
  logic [SCW-1:0]  scan_cnt;
  logic [DSW-1:0]  sel, next_sel;
  logic            wrap;
  logic [3:0]      digit;
  logic [6:0]      seg_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      idx   <= enc;
      valid <= |sync2;
    end
  end

  // Highest set bit wins: later iterations overwrite lower ones.
  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++)
      if (sync2[i]) enc = OUTW'(i);
  end

  assign changed = (idx != conv_idx) || (valid != conv_valid);

  always_comb begin
    bcd_adj = bcd_work;
    for (int k = 0; k < DIGITS; k++)
      if (bcd_work[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      pending    <= 1'b0;
      conv_idx   <= '0;
      conv_valid <= 1'b0;
      bin_work   <= '0;
      bcd_work   <= '0;
      shift_cnt  <= '0;
      bcd        <= '0;
      bcd_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending || changed) begin
            state      <= SHIFT;
            busy       <= 1'b1;
            pending    <= 1'b0;
            conv_idx   <= idx;
            conv_valid <= valid;
            bin_work   <= idx;
            bcd_work   <= '0;
            shift_cnt  <= '0;
          end
        end
        SHIFT: begin
          {bcd_work, bin_work} <= {bcd_adj, bin_work} << 1;
          shift_cnt            <= shift_cnt + CW'(1);
          if (shift_cnt == CW'(OUTW - 1)) state <= DONE;
          if (changed) pending <= 1'b1;
        end
        DONE: begin
          bcd       <= bcd_work;
          bcd_valid <= conv_valid;
          state     <= IDLE;
          busy      <= 1'b0;
          if (changed) pending <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wrap = (scan_cnt == SCW'(REFRESH_DIV - 1));

  always_comb begin
    next_sel = sel;
    if (wrap) next_sel = (sel == DSW'(DIGITS - 1)) ? '0 : sel + DSW'(1);
  end

  // Decode from next_sel so seg_out and an register on the same edge.
  always_comb begin
    digit = 4'd0;
    for (int k = 0; k < DIGITS; k++)
      if (next_sel == DSW'(k)) digit = bcd[4*k +: 4];
    case (digit)
      4'd0:    seg_next = 7'h40;
      4'd1:    seg_next = 7'h79;
      4'd2:    seg_next = 7'h24;
      4'd3:    seg_next = 7'h30;
      4'd4:    seg_next = 7'h19;
      4'd5:    seg_next = 7'h12;
      4'd6:    seg_next = 7'h02;
      4'd7:    seg_next = 7'h78;
      4'd8:    seg_next = 7'h00;
      4'd9:    seg_next = 7'h10;
      default: seg_next = 7'h7F;
    endcase
`ifdef PRIO_SEG_LZ_BLANK_EN
    for (int k = 1; k < DIGITS; k++)
      if (next_sel == DSW'(k) && (bcd >> (4 * k)) == '0) seg_next = 7'h7F;
`endif
    if (!bcd_valid) seg_next = 7'h3F;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      sel      <= '0;
      an       <= '1;
      seg_out  <= 7'h7F;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + SCW'(1);
      sel      <= next_sel;
      an       <= ~(DIGITS'(1) << next_sel);
      seg_out  <= seg_next;
    end
  end
endmodule
`default_nettype wire
